// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity-mode constants.
// Used by the RX framer, the retransmission FSM and the TX side.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } uart_rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Receive-side bundle: serial line and resend strobe in, byte and result strobes out.
interface uart_rx_framer_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 rx;
  logic                 request_resend;
  logic [DATA_BITS-1:0] data;
  logic                 frame_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 timeout;

  modport master (
    output rx, request_resend,
    input  data, frame_valid, parity_error, framing_error, timeout
  );

  modport slave (
    input  rx, request_resend,
    output data, frame_valid, parity_error, framing_error, timeout
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (line idle).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive deframer: oversampled start/data/parity/stop decode with result
// strobes, plus the resend timeout timer armed by request_resend.
module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned TIMEOUT_CLKS = 1024
) (
  input logic             clk,
  input logic             reset,
  uart_rx_framer_if.slave bus
);
  import uart_pkg::*;

  localparam int unsigned      CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned      TmrW     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CntW-1:0]  HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IdxLast  = 3'(DATA_BITS - 1);
  localparam logic [TmrW-1:0]  TmrLoad  = TmrW'(TIMEOUT_CLKS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.rx),
    .sync_o  (rx_s)
  );

  uart_rx_state_e       state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 par_q, par_d;
  logic                 fv_q, fv_d, pe_q, pe_d, fe_q, fe_d;
  logic [TmrW-1:0]      tmr_q, tmr_d;
  logic                 armed_q, armed_d, to_q, to_d;
  logic                 start_ok, bit_tick;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    fv_d     = 1'b0;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    start_ok = 1'b0;
    bit_tick = (cnt_q == BitLast);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d  = StData;
            start_ok = 1'b1;
            idx_d    = '0;
            par_d    = 1'b0;
          end
        end
      end
      StData: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx_s;
          idx_d   = idx_q + 3'd1;
          if (idx_q == IdxLast) state_d = StParity;
        end
      end
      StParity: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = par_q ^ rx_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            fv_d    = (par_q == PARITY_ODD);
            pe_d    = (par_q != PARITY_ODD);
            state_d = StIdle;
          end else begin
            // Bad stop bit: keep the old byte and wait for the line to return high.
            fe_d    = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A new request always wins over both a confirmed start and expiry.
  always_comb begin
    tmr_d   = tmr_q;
    armed_d = armed_q;
    to_d    = 1'b0;
    if (bus.request_resend) begin
      tmr_d   = TmrLoad;
      armed_d = (TIMEOUT_CLKS != 1);
      to_d    = (TIMEOUT_CLKS == 1);
    end else if (start_ok) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      if (tmr_q == TmrW'(1)) begin
        to_d    = 1'b1;
        armed_d = 1'b0;
      end else begin
        tmr_d = tmr_q - TmrW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      tmr_q   <= '0;
      armed_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      tmr_q   <= tmr_d;
      armed_q <= armed_d;
      to_q    <= to_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.frame_valid   = fv_q;
  assign bus.parity_error  = pe_q;
  assign bus.framing_error = fe_q;
  assign bus.timeout       = to_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: table-driven frames, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_uart_rx_framer;
  import uart_pkg::*;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Db  = 8;
  localparam int unsigned Tmo = 100;
  // rx pin edge -> strobe: 2 sync + H + (DB+2) bits + 1 register.
  localparam int StrobeLat = 2 + Cpb / 2 + (Db + 2) * Cpb + 1;

  localparam int KValid = 0;
  localparam int KParity = 1;
  localparam int KFraming = 2;
  localparam int KTimeout = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx_framer_if #(.DATA_BITS(Db)) bus ();

  uart_rx_framer #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (Db),
    .PARITY_ODD   (PARITY_EVEN),
    .TIMEOUT_CLKS (Tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       fv;
    logic       pe;
    logic       fe;
    logic       to;
    logic [7:0] data;
  } ev_t;
  ev_t ev_q[$];

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         kind;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_valid || bus.parity_error || bus.framing_error || bus.timeout) begin
      ev_q.push_back('{cyc, bus.frame_valid, bus.parity_error, bus.framing_error,
                       bus.timeout, bus.data});
      chk("exclusive", 32'((int'(bus.frame_valid) + int'(bus.parity_error)
                            + int'(bus.framing_error)) <= 1), 32'd1);
    end
  end

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    if (cyc < c) step(c - cyc);
  endtask

  // Frame-level model: result class from the parity rule and stop bit alone.
  function automatic int model_kind(input logic [7:0] d, input logic p, input logic s);
    if (!s) return KFraming;
    return ((^d ^ p) == PARITY_EVEN) ? KValid : KParity;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int stop_len, output int e);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    e = cyc;
    for (int k = 0; k < 11; k++) begin
      bus.rx = bits[k];
      step((k == 10) ? stop_len : Cpb);
    end
  endtask

  task automatic check_ev(input string name, input int exp_cyc, input int kind,
                          input logic [7:0] d);
    ev_t ev;
    chk({name, "_present"}, 32'(ev_q.size() > 0), 32'd1);
    if (ev_q.size() > 0) begin
      ev = ev_q.pop_front();
      chk({name, "_cycle"}, ev.cyc, exp_cyc);
      chk({name, "_flags"}, {ev.fv, ev.pe, ev.fe, ev.to},
          {kind == KValid, kind == KParity, kind == KFraming, kind == KTimeout});
      chk({name, "_data"}, ev.data, d);
    end
  endtask

  task automatic check_quiet(input string name);
    chk(name, ev_q.size(), 0);
    ev_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, r, n_rand;
    logic [7:0] d;
    logic p;
    int kind;

    bus.rx = 1'b1;
    bus.request_resend = 1'b0;

    tbl[0] = '{8'hA5, 1'b0, KValid,  8'hA5};
    tbl[1] = '{8'hA5, 1'b1, KParity, 8'hA5};
    tbl[2] = '{8'h00, 1'b0, KValid,  8'h00};
    tbl[3] = '{8'hFF, 1'b0, KValid,  8'hFF};
    tbl[4] = '{8'h01, 1'b0, KParity, 8'h01};
    tbl[5] = '{8'h01, 1'b1, KValid,  8'h01};

    step(3);
    chk("reset_data", bus.data, 0);
    chk("reset_strobes", {bus.frame_valid, bus.parity_error, bus.framing_error,
                          bus.timeout}, 4'b0000);
    reset = 1'b0;
    step(5);

    foreach (tbl[i]) begin
      send_frame(tbl[i].d, tbl[i].p, 1'b1, Cpb, e);
      wait_until(e + StrobeLat + 2);
      check_ev($sformatf("tbl%0d", i), e + StrobeLat, tbl[i].kind, tbl[i].exp_data);
      last_data = tbl[i].exp_data;
      step(3);
    end
    check_quiet("tbl_quiet");

    // Framing error followed by a long break, then recovery.
    send_frame(8'h3C, 1'b0, 1'b0, Cpb, e);
    bus.rx = 1'b0;
    wait_until(e + StrobeLat + 2);
    check_ev("framing", e + StrobeLat, KFraming, last_data);
    step(20 * Cpb);
    check_quiet("break_quiet");
    bus.rx = 1'b1;
    step(10);
    send_frame(8'h3C, 1'b0, 1'b1, Cpb, e);
    wait_until(e + StrobeLat + 2);
    check_ev("after_break", e + StrobeLat, KValid, 8'h3C);
    last_data = 8'h3C;
    step(5);

    // Timeout from an idle line, with a one-cycle glitch in the window.
    r = cyc;
    bus.request_resend = 1'b1;
    step(1);
    bus.request_resend = 1'b0;
    step(19);
    bus.rx = 1'b0;
    step(1);
    bus.rx = 1'b1;
    wait_until(r + Tmo + 5);
    check_ev("timeout", r + Tmo, KTimeout, last_data);
    check_quiet("glitch_quiet");

    // Confirmed start at R+50 cancels the pending timeout.
    r = cyc;
    bus.request_resend = 1'b1;
    step(1);
    bus.request_resend = 1'b0;
    wait_until(r + 46);
    send_frame(8'hA5, 1'b0, 1'b1, Cpb, e);
    wait_until(r + Tmo + 10);
    check_ev("cancel_frame", e + StrobeLat, KValid, 8'hA5);
    check_quiet("cancel_no_timeout");
    last_data = 8'hA5;

    // Next start lands on rx_s exactly one cycle after the stop sample.
    send_frame(8'h69, 1'b0, 1'b1, Cpb - 1, e);
    send_frame(8'h96, 1'b1, 1'b1, Cpb, e2);
    chk("b2b_spacing", e2 - e, 32'(Cpb * 11 - 1));
    wait_until(e2 + StrobeLat + 2);
    check_ev("b2b_first", e + StrobeLat, KValid, 8'h69);
    check_ev("b2b_second", e2 + StrobeLat, KParity, 8'h96);
    check_quiet("b2b_quiet");
    last_data = 8'h96;
    step(5);

    // Reset in the middle of data bit 3.
    d = 8'h5A;
    bus.rx = 1'b0;
    step(Cpb);
    for (int k = 0; k < 3; k++) begin
      bus.rx = d[k];
      step(Cpb);
    end
    bus.rx = d[3];
    step(2);
    reset = 1'b1;
    #1;
    chk("midreset_data", bus.data, 0);
    chk("midreset_strobes", {bus.frame_valid, bus.parity_error, bus.framing_error,
                             bus.timeout}, 4'b0000);
    bus.rx = 1'b1;
    step(3);
    reset = 1'b0;
    step(5);
    check_quiet("midreset_quiet");
    send_frame(8'h5A, 1'b0, 1'b1, Cpb, e);
    wait_until(e + StrobeLat + 2);
    check_ev("after_reset", e + StrobeLat, KValid, 8'h5A);
    last_data = 8'h5A;

    // Random frames against the model.
    n_rand = 24;
    for (int i = 0; i < n_rand; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      kind = model_kind(d, p, 1'b1);
      step($urandom_range(0, 3));
      send_frame(d, p, 1'b1, Cpb, e);
      wait_until(e + StrobeLat + 2);
      if (kind != KFraming) last_data = d;
      check_ev($sformatf("rand%0d", i), e + StrobeLat, kind, last_data);
    end
    step(10);
    check_quiet("final_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

UART receive deframer that turns the asynchronous serial line into parallel bytes plus the `frame_valid` / `parity_error` strobes, and the resend `timeout`, consumed by the retransmission FSM directly downstream. It oversamples `rx` at `CLKS_PER_BIT` clocks per bit, checks parity and stop bit, and times the wait for a resent frame after each `request_resend`.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per UART bit. Legal range is ≥ 4. Half-bit H = CLKS_PER_BIT/2, using integer division.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first. Legal range is 5–8.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `TIMEOUT_CLKS`, default 1024: clocks from `request_resend` to `timeout`. Must be ≥ 1.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `rx` input, 1 bit: serial line, idle high, asynchronous to `clk`.
- `request_resend` input, 1 bit: strobe from the downstream FSM that arms the timeout timer.
- `data` output, `DATA_BITS` bits: last received byte. Held until the next frame completes.
- `frame_valid` output, 1 bit: one-cycle pulse for a frame with good parity and good stop bit.
- `parity_error` output, 1 bit: one-cycle pulse for a parity mismatch when the stop bit is good.
- `framing_error` output, 1 bit: one-cycle pulse when the stop bit is sampled 0.
- `timeout` output, 1 bit: one-cycle pulse when the resend window expires.

## Operation
- Synchronisation:
  - `rx` passes through a 2-flop synchronizer to produce `rx_s`; `rx_s` lags `rx` by 2 cycles.
  - All decisions use `rx_s` only.
- Bit counter: one `$clog2(CLKS_PER_BIT)`-bit counter plus a bit index.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - On `rx_s`=0, go to START. Call this cycle T0.
- START:
  - At T0+H, sample `rx_s`.
  - If it is 0, go to DATA. This is a confirmed start.
  - If it is 1, treat it as a false start: go to IDLE with no output.
- DATA:
  - Data bit i (i = 0..DATA_BITS-1) is sampled at T0+H+(i+1)·CLKS_PER_BIT and shifted in LSB first.
- PARITY:
  - The parity bit is sampled at T0+H+(DATA_BITS+1)·CLKS_PER_BIT.
  - The check passes when XOR(data bits, parity bit) = `PARITY_ODD`.
- STOP:
  - The stop bit is sampled at Ts = T0+H+(DATA_BITS+2)·CLKS_PER_BIT.
  - Stop = 1 and parity good: `data` updates and `frame_valid` pulses; next state IDLE.
  - Stop = 1 and parity bad: `data` updates and `parity_error` pulses; next state IDLE.
  - Stop = 0: `framing_error` only. `data` is not updated and parity is not reported. Next state BREAK.
- BREAK:
  - Stay until `rx_s`=1, then go to IDLE.
  - No start detection while in BREAK.
- Mutual exclusion: `frame_valid`, `parity_error` and `framing_error` are never high together.
- Timeout timer:
  - `request_resend`=1 loads the counter with TIMEOUT_CLKS and arms it.
  - While armed, the counter decrements every cycle, including during false starts.
  - A confirmed start disarms it with no pulse.
  - On reaching 0 it pulses `timeout` and disarms.
- Simultaneous events:
  - `request_resend` together with a confirmed start: the timer re-arms, because `request_resend` wins.
  - `request_resend` together with expiry: no `timeout` pulse; the counter reloads.
  - `request_resend` while already armed: the counter reloads.
- Reset:
  - Any state goes to IDLE. `data`=0. All strobes 0. Timer disarmed. Synchronizer flops set to 1 (idle).
  - Reset mid-frame discards the partial frame.

## Timing
- Reset value of every output is 0.
- Result strobes are registered and high in cycle Ts+1 only.
- `data` is valid from Ts+1 onward.
- Back-to-back frames:
  - After a good stop bit the FSM is in IDLE at Ts+1.
  - A start bit whose `rx_s` falling edge lands at Ts+1 or later is received.
- Example with CLKS_PER_BIT=4 and DATA_BITS=8:
  - H=2, Ts=T0+42, strobe at T0+43.
  - Measured from the `rx` pin edge, the strobe is at +45.
- Timeout: `request_resend` high in cycle R gives `timeout` high in cycle R+TIMEOUT_CLKS.

## Structure
- Shared package `uart_pkg`:
  - State encoding localparams (IDLE..BREAK, 3 bits).
  - Parity-mode constants `PARITY_EVEN`=0 and `PARITY_ODD`=1.
  - Shared with the retransmission FSM and the future TX side.
- Sub-module `uart_rx_sync`:
  - 2-flop synchronizer, reset to 1.
  - Instantiated once; reusable for other async inputs.
- Everything else is a single module: FSM, bit counter, shift register, parity accumulator, timeout counter.

## Test plan
Common settings: CLKS_PER_BIT=4, DATA_BITS=8, even parity, TIMEOUT_CLKS=100.
- Good frame: send 0xA5 with parity bit 0 and stop 1 → `frame_valid` for exactly 1 cycle at T0+43, `data`=0xA5, other strobes 0.
- Bad parity: send 0xA5 with parity bit 1 → `parity_error` 1 cycle, `frame_valid` 0, `data`=0xA5.
- Framing error:
  - Send 0x3C with stop bit 0, then hold `rx` low 20 bit-times → one `framing_error` pulse, `data` unchanged, no further strobes.
  - Release `rx` high, then send 0x3C → `frame_valid` with `data`=0x3C.
- Glitch: `rx` low for 1 cycle → no strobe, FSM back in IDLE, no effect on the timer.
- Timeout:
  - `request_resend` at cycle R with the line idle → `timeout` at R+100 only.
  - Repeat with a start bit confirmed at R+50 → no `timeout`; `frame_valid` on completion.
- Reset mid-frame: assert `reset` during data bit 3 → all outputs 0 immediately. After release, send 0x5A → `frame_valid` with `data`=0x5A.
